gate_truth_checker: RTL and testbench

//   Synthesizable stimulus/response checker for small combinational gate models.

---
 rtl/gate_chk_pkg.sv | 18 +
 rtl/gate_chk_seq.sv | 42 ++++
 rtl/gate_truth_checker.sv | 152 +++++++++++++++
 tb/tb_gate_truth_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker: FSM state encoding
// and golden truth tables for the common two-input gates.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } chkState_e;

  // Bit v of each table is the expected gate output for input vector v.
  localparam logic [3:0] TT_OR2  = 4'b1110;
  localparam logic [3:0] TT_AND2 = 4'b1000;
  localparam logic [3:0] TT_XOR2 = 4'b0110;
  localparam logic [3:0] TT_NOR2 = 4'b0001;

endpackage

// File: rtl/gate_chk_seq.sv
// Vector counter and settle timer for the truth-table checker. The FSM in
// the top decides when to restart or advance; this block only keeps count.
module gate_chk_seq #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_restart,
  input  logic            i_advance,
  input  logic            i_run,
  output logic [N_IN-1:0] o_vec,
  output logic            o_sampleEn
);

  // The timer only ever holds SETTLE-1 down to 0, so size it to that range.
  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(SETTLE - 1);

  logic [N_IN-1:0] r_vec;
  logic [TW-1:0]   r_timer;

  // Restart returns to vector 0, advance steps to the next vector; both reload the settle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec   <= '0;
      r_timer <= '0;
    end else if (i_restart) begin
      r_vec   <= '0;
      r_timer <= RELOAD;
    end else if (i_advance) begin
      r_vec   <= r_vec + N_IN'(1);
      r_timer <= RELOAD;
    end else if (i_run && (r_timer != '0)) begin
      r_timer <= r_timer - TW'(1);
    end
  end

  assign o_vec      = r_vec;
  assign o_sampleEn = (r_timer == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector of an N_IN-input gate across N_DUT parallel
// implementations, compares their outputs with a golden truth table and
// reports pass/fail, a mismatch count and the first failing vector.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter int                    N_DUT  = 3,
  parameter int                    SETTLE = 1,
  parameter logic [(2**N_IN)-1:0]  TT     = TT_OR2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_DUT-1:0] dut_out,
  output logic [N_IN-1:0]  drv_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_cnt,
  output logic [N_IN-1:0]  first_err_vec,
  output logic [N_DUT-1:0] first_err_mask
);

  localparam logic [N_IN-1:0] LAST_VEC = N_IN'((2**N_IN) - 1);

  chkState_e        r_state;
  chkState_e        w_nextState;
  logic             w_restart;
  logic             w_advance;
  logic             w_abortRun;
  logic             w_sampleEn;
  logic [N_IN-1:0]  w_vec;
  logic [N_DUT-1:0] w_mask;

  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [N_IN:0]    r_errCnt;
  logic [N_IN-1:0]  r_firstErrVec;
  logic [N_DUT-1:0] r_firstErrMask;

  gate_chk_seq #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_restart  (w_restart | w_abortRun),
    .i_advance  (w_advance),
    .i_run      (r_state == ST_SETTLE),
    .o_vec      (w_vec),
    .o_sampleEn (w_sampleEn)
  );

  // Every DUT is expected to produce the same golden bit for the current vector.
  assign w_mask = dut_out ^ {N_DUT{TT[w_vec]}};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; abort beats start, and start is only heard in IDLE.
  always_comb begin
    w_nextState = r_state;
    w_restart   = 1'b0;
    w_advance   = 1'b0;
    w_abortRun  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_nextState = ST_SETTLE;
          w_restart   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          w_nextState = ST_IDLE;
          w_abortRun  = 1'b1;
        end else if (w_sampleEn) begin
          w_nextState = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          w_nextState = ST_IDLE;
          w_abortRun  = 1'b1;
        end else if (w_vec == LAST_VEC) begin
          w_nextState = ST_DONE;
        end else begin
          w_nextState = ST_SETTLE;
          w_advance   = 1'b1;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Result registers: cleared on an accepted start, accumulated in SAMPLE, published in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_errCnt       <= '0;
      r_firstErrVec  <= '0;
      r_firstErrMask <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_restart) begin
        r_busy         <= 1'b1;
        r_pass         <= 1'b0;
        r_errCnt       <= '0;
        r_firstErrVec  <= '0;
        r_firstErrMask <= '0;
      end else if (w_abortRun) begin
        r_busy <= 1'b0;
        r_pass <= 1'b0;
      end else if ((r_state == ST_SAMPLE) && (w_mask != '0)) begin
        r_errCnt <= r_errCnt + (N_IN+1)'(1);
        if (r_errCnt == '0) begin
          r_firstErrVec  <= w_vec;
          r_firstErrMask <= w_mask;
        end
      end else if (r_state == ST_DONE) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_pass <= (r_errCnt == '0);
      end
    end
  end

  assign drv_in         = w_vec;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_errCnt;
  assign first_err_vec  = r_firstErrVec;
  assign first_err_mask = r_firstErrMask;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: an OR2 checker with modelled DUTs
// (optionally stuck-at-0) and an AND2 checker with a longer settle window.
module tb_gate_truth_checker;
  import gate_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic       abort;
  logic [2:0] stuckMask;
  logic [2:0] dutOut;
  logic [1:0] drvIn;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] errCnt;
  logic [1:0] firstErrVec;
  logic [2:0] firstErrMask;

  logic       start2;
  logic [2:0] dutOut2;
  logic [1:0] drvIn2;
  logic       busy2;
  logic       done2;
  logic       pass2;
  logic [2:0] errCnt2;
  logic [1:0] firstErrVec2;
  logic [2:0] firstErrMask2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // OR2 DUT models with per-DUT stuck-at-0 injection; AND2 models are always correct.
  assign dutOut  = {3{|drvIn}} & ~stuckMask;
  assign dutOut2 = {3{&drvIn2}};

  gate_truth_checker #(
    .N_IN(2), .N_DUT(3), .SETTLE(1), .TT(TT_OR2)
  ) dut (
    .clk(clk), .rst_n(rstN), .start(start), .abort(abort), .dut_out(dutOut),
    .drv_in(drvIn), .busy(busy), .done(done), .pass(pass), .err_cnt(errCnt),
    .first_err_vec(firstErrVec), .first_err_mask(firstErrMask)
  );

  gate_truth_checker #(
    .N_IN(2), .N_DUT(3), .SETTLE(3), .TT(TT_AND2)
  ) dut2 (
    .clk(clk), .rst_n(rstN), .start(start2), .abort(1'b0), .dut_out(dutOut2),
    .drv_in(drvIn2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(errCnt2),
    .first_err_vec(firstErrVec2), .first_err_mask(firstErrMask2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse start on the OR2 checker and wait for done; hist packs drv_in after edges k..k+7.
  task automatic applyStimulus(input int budget, output int latency,
                               output logic [15:0] hist);
    latency = 0;
    hist    = '0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    hist[1:0] = drvIn;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (c < 8) hist[2*c +: 2] = drvIn;
      if (done) begin
        latency = c;
        break;
      end
    end
  endtask

  int          lat;
  logic [15:0] hist;
  logic [31:0] hist2;
  int          doneCount;
  int          doneAt;

  initial begin
    rstN      = 1'b1;
    start     = 1'b0;
    start2    = 1'b0;
    abort     = 1'b0;
    stuckMask = 3'b000;
    #2 rstN = 1'b0;
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_pass", pass, 0);
    checkOutput("reset_errcnt", errCnt, 0);
    checkOutput("reset_drv", drvIn, 0);
    checkOutput("reset_mask", firstErrMask, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    tick();

    // 1: three correct OR2 DUTs
    applyStimulus(20, lat, hist);
    checkOutput("t1_latency", lat, 9);
    checkOutput("t1_drv_hist", hist, 16'hFA50);
    checkOutput("t1_pass", pass, 1);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_errcnt", errCnt, 0);
    checkOutput("t1_first_vec", firstErrVec, 0);
    checkOutput("t1_first_mask", firstErrMask, 0);
    tick();
    checkOutput("t1_done_one_cycle", done, 0);
    checkOutput("t1_pass_hold", pass, 1);

    // 2: DUT1 stuck at 0 mismatches on vectors 01, 10, 11
    stuckMask = 3'b010;
    applyStimulus(20, lat, hist);
    checkOutput("t2_latency", lat, 9);
    checkOutput("t2_pass", pass, 0);
    checkOutput("t2_errcnt", errCnt, 3);
    checkOutput("t2_first_vec", firstErrVec, 2'b01);
    checkOutput("t2_first_mask", firstErrMask, 3'b010);

    // 3: abort while vector 10 is settling; partial results stay
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checkOutput("t3_drv_before_abort", drvIn, 2'b10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t3_drv_after_abort", drvIn, 0);
    checkOutput("t3_busy_after_abort", busy, 0);
    checkOutput("t3_partial_errcnt", errCnt, 1);
    checkOutput("t3_partial_first_vec", firstErrVec, 2'b01);
    doneCount = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) doneCount++;
      tick();
    end
    checkOutput("t3_no_done", doneCount, 0);
    stuckMask = 3'b000;
    applyStimulus(20, lat, hist);
    checkOutput("t3_restart_latency", lat, 9);
    checkOutput("t3_restart_pass", pass, 1);
    checkOutput("t3_restart_errcnt", errCnt, 0);

    // 4: asynchronous reset in the middle of a sweep
    stuckMask = 3'b010;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checkOutput("t4_errcnt_before_rst", errCnt, 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("t4_rst_busy", busy, 0);
    checkOutput("t4_rst_drv", drvIn, 0);
    checkOutput("t4_rst_errcnt", errCnt, 0);
    checkOutput("t4_rst_first_mask", firstErrMask, 0);
    @(negedge clk);
    rstN = 1'b1;
    stuckMask = 3'b000;
    applyStimulus(20, lat, hist);
    checkOutput("t4_after_rst_latency", lat, 9);
    checkOutput("t4_after_rst_pass", pass, 1);

    // 5: start pulses while busy and while in DONE are ignored
    start = 1'b1;
    tick();
    doneCount = 0;
    doneAt    = 0;
    for (int c = 1; c <= 24; c++) begin
      start = (c == 3) || (c == 9);
      tick();
      if (done) begin
        doneCount++;
        if (doneAt == 0) doneAt = c;
      end
    end
    start = 1'b0;
    checkOutput("t5_done_count", doneCount, 1);
    checkOutput("t5_done_at", doneAt, 9);
    checkOutput("t5_idle_busy", busy, 0);

    // 6: AND2 checker with SETTLE=3 holds each vector four cycles
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    hist2 = '0;
    hist2[1:0] = drvIn2;
    doneAt = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c < 16) hist2[2*c +: 2] = drvIn2;
      if (done2) begin
        doneAt = c;
        break;
      end
    end
    checkOutput("t6_latency", doneAt, 17);
    checkOutput("t6_drv_hist", hist2, 32'hFFAA5500);
    checkOutput("t6_pass", pass2, 1);
    checkOutput("t6_errcnt", errCnt2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
